// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: LSB-first deserialiser, token-based word alignment, 8b/C0C1 decode.
// Latency: outputs update on the edge sampling a word's last bit; no backpressure (free-running serial input).
module tmds_channel_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int MAX_GAP    = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] d_out,
    output logic       C0,
    output logic       C1,
    output logic       disp_enable,
    output logic       data_valid,
    output logic       locked
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [9:0]      r_sr;
    logic [3:0]      r_bit_cnt;
    logic [3:0]      r_fill;
    logic [CW-1:0]   r_confirm;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_d;
    logic            r_c0, r_c1, r_de, r_dv, r_locked;

    logic [9:0]      w_word;
    logic            w_full, w_boundary, w_is_tok, w_gap_max, w_confirm_done;
    logic [1:0]      w_tok_code;
    logic            w_hunt_hit, w_ld_ctrl, w_ld_data, w_drop;

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] t;
        logic [7:0] d;
        t    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++)
            d[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return d;
    endfunction

    // Candidate word includes the bit being sampled on this edge.
    assign w_word         = {serial_in, r_sr[9:1]};
    assign w_full         = (r_fill == 4'd9);
    assign w_boundary     = (r_bit_cnt == 4'd9);
    assign w_gap_max      = (r_gap == GW'(MAX_GAP - 1));
    assign w_confirm_done = (r_confirm == CW'(LOCK_COUNT - 1));

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_code = 2'b00;
        case (w_word)
            10'b1101010100: w_tok_code = 2'b00;
            10'b0010101011: w_tok_code = 2'b01;
            10'b0101010100: w_tok_code = 2'b10;
            10'b1010101011: w_tok_code = 2'b11;
            default:        w_is_tok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_HUNT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT:   if (w_full && w_is_tok) w_state_nxt = S_VERIFY;
            S_VERIFY: if (w_boundary) w_state_nxt = !w_is_tok ? S_HUNT :
                                                    (w_confirm_done ? S_LOCKED : S_VERIFY);
            S_LOCKED: if (w_boundary && !w_is_tok && w_gap_max) w_state_nxt = S_HUNT;
            default:  w_state_nxt = S_HUNT;
        endcase
    end

    always_comb begin
        w_hunt_hit = (r_state == S_HUNT) && w_full && w_is_tok;
        w_ld_ctrl  = w_boundary && w_is_tok &&
                     (((r_state == S_VERIFY) && w_confirm_done) || (r_state == S_LOCKED));
        w_ld_data  = (r_state == S_LOCKED) && w_boundary && !w_is_tok && !w_gap_max;
        w_drop     = (r_state == S_LOCKED) && w_boundary && !w_is_tok && w_gap_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_fill    <= '0;
            r_confirm <= '0;
            r_gap     <= '0;
            r_d       <= '0;
            r_c0      <= 1'b0;
            r_c1      <= 1'b0;
            r_de      <= 1'b0;
            r_dv      <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_sr      <= w_word;
            r_bit_cnt <= (w_hunt_hit || w_boundary) ? 4'd0 : r_bit_cnt + 4'd1;
            // Re-entering HUNT discards history so the first compare is a full fresh word.
            if (w_state_nxt == S_HUNT && r_state != S_HUNT) r_fill <= 4'd0;
            else if (!w_full)                               r_fill <= r_fill + 4'd1;
            if (w_hunt_hit)
                r_confirm <= CW'(1);
            else if (r_state == S_VERIFY && w_boundary && w_is_tok)
                r_confirm <= r_confirm + CW'(1);
            r_dv <= w_ld_ctrl || w_ld_data;
            if (w_ld_ctrl) begin
                r_gap    <= '0;
                r_de     <= 1'b0;
                r_c0     <= w_tok_code[0];
                r_c1     <= w_tok_code[1];
                r_d      <= 8'h00;
                r_locked <= 1'b1;
            end
            if (w_ld_data) begin
                r_gap <= r_gap + GW'(1);
                r_de  <= 1'b1;
                r_d   <= tmds_decode(w_word);
            end
            if (w_drop) begin
                r_locked <= 1'b0;
                r_de     <= 1'b0;
            end
        end
    end

    assign d_out       = r_d;
    assign C0          = r_c0;
    assign C1          = r_c1;
    assign disp_enable = r_de;
    assign data_valid  = r_dv;
    assign locked      = r_locked;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: expected words queued at send time, popped on data_valid.
module tb_tmds_channel_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in;
    logic [7:0] d_out;
    logic       C0, C1, disp_enable, data_valid, locked;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] D00   = 10'b0100000000;
    localparam logic [9:0] DFE   = 10'b1011111111;
    localparam logic [9:0] DFF   = 10'b0011111111;

    int          checks = 0;
    int          failures = 0;
    int          dv_count = 0;
    int          n_pushed = 0;
    int          cyc = 0;
    int          last_dv_cyc = 0;
    int          last_spacing = 0;
    logic        prev_dv = 1'b0;
    logic [10:0] sb_q[$];

    tmds_channel_decoder #(.LOCK_COUNT(4), .MAX_GAP(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .d_out       (d_out),
        .C0          (C0),
        .C1          (C1),
        .disp_enable (disp_enable),
        .data_valid  (data_valid),
        .locked      (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic de, input logic [1:0] c, input logic [7:0] d);
        sb_q.push_back({de, c, d});
        n_pushed++;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    // Lands just after the edge that samples the last driven bit, before the next drive.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_d"},      d_out, 0);
        chk({tag, "_c"},      {C1, C0}, 0);
        chk({tag, "_de"},     disp_enable, 0);
        chk({tag, "_dv"},     data_valid, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            dv_count++;
            last_spacing = cyc - last_dv_cyc;
            last_dv_cyc  = cyc;
            chk("dv_single", prev_dv, 0);
            if (sb_q.size() == 0) chk("dv_expected", data_valid, 0);
            else                  chk("word", {disp_enable, C1, C0, d_out}, sb_q.pop_front());
        end
        prev_dv = data_valid;
    end

    logic [9:0] pats [3];
    logic [7:0] pexp [3];

    initial begin
        serial_in = 1'b0;
        pats = '{D00, DFE, DFF};
        pexp = '{8'h00, 8'hFE, 8'hFF};
        #1 rst = 1'b1;
        #3;
        chk_reset_outputs("rst_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Lock acquisition after three junk bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_word(TOK00);
        settle();
        chk("lock_early", locked, 0);
        push(1'b0, 2'b00, 8'h00);
        send_word(TOK00);
        settle();
        chk("lock_4th", locked, 1);

        // Data decode
        push(1'b1, 2'b00, 8'h00); send_word(D00);
        push(1'b1, 2'b00, 8'hFE); send_word(DFE);
        push(1'b1, 2'b00, 8'hFF); send_word(DFF);
        settle();
        chk("data_de", disp_enable, 1);

        // Control tokens then C-bit hold across data
        push(1'b0, 2'b01, 8'h00); send_word(TOK01);
        push(1'b0, 2'b10, 8'h00); send_word(TOK10);
        push(1'b0, 2'b11, 8'h00); send_word(TOK11);
        settle();
        chk("ctl_de", disp_enable, 0);
        chk("ctl_d", d_out, 0);
        push(1'b1, 2'b11, 8'hFE); send_word(DFE);
        settle();
        chk("c_hold", {C1, C0}, 2'b11);
        chk("dv_spacing", last_spacing, 10);

        // Gap limit: eight data words after a token, the eighth drops lock
        push(1'b0, 2'b00, 8'h00); send_word(TOK00);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) push(1'b1, 2'b00, pexp[(i + 1) % 3]);
            send_word(pats[(i + 1) % 3]);
        end
        settle();
        chk("loss_locked", locked, 0);
        chk("loss_de", disp_enable, 0);
        chk("loss_d_hold", d_out, 8'hFE);
        chk("loss_c_hold", {C1, C0}, 2'b00);

        repeat (3) send_word(TOK10);
        push(1'b0, 2'b10, 8'h00); send_word(TOK10);
        settle();
        chk("relock", locked, 1);
        push(1'b1, 2'b10, 8'hFE); send_word(DFE);
        settle();
        chk("relock_de", disp_enable, 1);

        // Asynchronous reset in the middle of a word
        for (int i = 0; i < 4; i++) send_bit(DFF[i]);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        // False start: two tokens then a data word at the boundary
        send_word(TOK00);
        send_word(TOK00);
        send_word(D00);
        settle();
        chk("false_locked", locked, 0);
        repeat (3) send_word(TOK11);
        push(1'b0, 2'b11, 8'h00); send_word(TOK11);
        settle();
        chk("final_lock", locked, 1);
        repeat (2) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);
        chk("dv_total", dv_count, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
